// File: rtl/line_buffer_pkg.sv
// Shared constants and helpers for the N-line sliding-row buffer.
package line_buffer_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_IMG_W     = 640;
  localparam int DEF_NUM_LINES = 3;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int lb_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of tap k on the packed tap bus.
  function automatic int tap_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line RAM: the read sees the old word, the write lands on the clock edge.
module line_ram
  import line_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [lb_width(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // NOTE: storage arrays carry no reset; clearing them would stop RAM inference
  // and stale contents are masked upstream by the row count anyway.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/line_buffer_multi.sv
// N-line sliding-row buffer: NUM_LINES vertically aligned taps from a raster pixel stream.
// Build option LB_REPLICATE_BORDER_EN: unfilled taps repeat the oldest valid row instead of 0.
module line_buffer_multi
  import line_buffer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic                        sof_i,
  input  logic [DATA_W-1:0]           data_i,
  output logic [NUM_LINES*DATA_W-1:0] data_o,
  output logic                        valid_o,
  output logic                        eol_o,
  output logic                        done_o
);

  localparam int COL_W = lb_width(IMG_W);
  localparam int ROW_W = lb_width(NUM_LINES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(NUM_LINES - 1);

  logic [COL_W-1:0] col, col_eff;
  logic [ROW_W-1:0] row_cnt, row_eff;
  logic [DATA_W-1:0] rd [NUM_LINES-1];
  logic [NUM_LINES*DATA_W-1:0] taps;

  // A start-of-frame write is placed at column 0 of row 0 regardless of history.
  assign col_eff = sof_i ? '0 : col;
  assign row_eff = sof_i ? '0 : row_cnt;
  assign done_o  = (row_cnt == ROW_FULL);

  for (genvar j = 0; j < NUM_LINES - 1; j++) begin : g_line
    logic [DATA_W-1:0] wr_d;
    if (j == 0) begin : g_head
      assign wr_d = data_i;
    end else begin : g_chain
      assign wr_d = rd[j-1];
    end
    line_ram #(.WIDTH(DATA_W), .DEPTH(IMG_W)) u_ram (
      .clk     (clk),
      .we      (we_i),
      .addr    (col_eff),
      .wr_data (wr_d),
      .rd_data (rd[j])
    );
  end

`ifdef LB_REPLICATE_BORDER_EN
  logic [DATA_W-1:0] oldest;
`endif

  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    taps = '0;
    taps[DATA_W-1:0] = data_i;
`ifdef LB_REPLICATE_BORDER_EN
    oldest = data_i;
    for (int k = 1; k < NUM_LINES; k++) begin
      if (k == int'(row_eff)) oldest = rd[k-1];
    end
`endif
    for (int k = 1; k < NUM_LINES; k++) begin
      if (k <= int'(row_eff)) begin
        taps[tap_lsb(k, DATA_W) +: DATA_W] = rd[k-1];
      end else begin
`ifdef LB_REPLICATE_BORDER_EN
        taps[tap_lsb(k, DATA_W) +: DATA_W] = oldest;
`else
        taps[tap_lsb(k, DATA_W) +: DATA_W] = '0;
`endif
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row_cnt <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      eol_o   <= 1'b0;
    end else begin
      valid_o <= we_i && (row_eff == ROW_FULL);
      eol_o   <= we_i && (col_eff == COL_LAST);
      if (we_i) begin
        data_o <= taps;
        if (col_eff == COL_LAST) begin
          col     <= '0;
          row_cnt <= (row_eff == ROW_FULL) ? row_eff : row_eff + 1'b1;
        end else begin
          col     <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
      end else if (sof_i) begin
        col     <= '0;
        row_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_multi.sv
// Self-checking bench for line_buffer_multi against a frame-position reference model.
module tb_line_buffer_multi;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int L  = 3;
`ifdef LB_REPLICATE_BORDER_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            we_i = 1'b0;
  logic            sof_i = 1'b0;
  logic [DW-1:0]   data_i = '0;
  logic [L*DW-1:0] data_o;
  logic            valid_o, eol_o, done_o;

  line_buffer_multi #(.DATA_W(DW), .IMG_W(W), .NUM_LINES(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_i),
    .sof_i   (sof_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .eol_o   (eol_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: pixels of the current frame, indexed by position since frame start.
  logic [DW-1:0]   hist[$];
  int              n = 0;
  logic [L*DW-1:0] exp_data = '0;
  logic            exp_valid = 1'b0, exp_eol = 1'b0, exp_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    n = 0;
    exp_data = '0;
    exp_valid = 1'b0;
    exp_eol = 1'b0;
    exp_done = 1'b0;
  endfunction

  function automatic void model_step(input logic we, input logic sof, input logic [DW-1:0] d);
    int row, col, rowc, last;
    logic [DW-1:0] oldest, tap;
    if (we) begin
      if (sof) begin
        hist.delete();
        n = 0;
      end
      hist.push_back(d);
      if (hist.size() > L * W) void'(hist.pop_front());
      row    = n / W;
      col    = n % W;
      rowc   = (row < L - 1) ? row : L - 1;
      last   = hist.size() - 1;
      oldest = hist[last - rowc * W];
      for (int j = 0; j < L; j++) begin
        if (j <= row) tap = hist[last - j * W];
        else          tap = REPL ? oldest : '0;
        exp_data[j*DW +: DW] = tap;
      end
      exp_valid = (row >= L - 1);
      exp_eol   = (col == W - 1);
      n++;
      exp_done  = (n >= (L - 1) * W);
    end else begin
      exp_valid = 1'b0;
      exp_eol   = 1'b0;
      if (sof) begin
        hist.delete();
        n = 0;
        exp_done = 1'b0;
      end
    end
  endfunction

  // Single compare process, on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_o", 64'(data_o), 64'(exp_data));
      check("valid_o", 64'(valid_o), 64'(exp_valid));
      check("eol_o", 64'(eol_o), 64'(exp_eol));
      check("done_o", 64'(done_o), 64'(exp_done));
    end
  end

  task automatic cycle(input logic we, input logic sof, input logic [DW-1:0] d);
    we_i   = we;
    sof_i  = sof;
    data_i = d;
    @(posedge clk);
    model_step(we, sof, d);
    #1;
    we_i  = 1'b0;
    sof_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    we_i = 1'b0;
    sof_i = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_eol", 64'(eol_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    // Priming, continuous writes of 1..12.
    for (int p = 1; p <= 12; p++) begin
      cycle(1'b1, 1'b0, DW'(p));
      if (p == 1)  check("p1_taps", 64'(data_o), REPL ? 64'h010101 : 64'h000001);
      if (p == 5)  check("p5_taps", 64'(data_o), REPL ? 64'h010105 : 64'h000105);
      if (p == 7)  check("p7_done", 64'(done_o), 64'd0);
      if (p == 8)  begin
        check("p8_valid", 64'(valid_o), 64'd0);
        check("p8_done", 64'(done_o), 64'd1);
      end
      if (p == 9)  begin
        check("p9_taps", 64'(data_o), {40'd0, 8'd1, 8'd5, 8'd9});
        check("p9_valid", 64'(valid_o), 64'd1);
      end
      if (p == 11) check("p11_eol", 64'(eol_o), 64'd0);
      if (p == 12) begin
        check("p12_taps", 64'(data_o), {40'd0, 8'd4, 8'd8, 8'd12});
        check("p12_eol", 64'(eol_o), 64'd1);
      end
    end

    // Gapped input, new frame via sof on the first pixel.
    for (int p = 1; p <= 12; p++) begin
      cycle(1'b1, p == 1, DW'(p));
      if (p == 9) check("gap_p9_taps", 64'(data_o), {40'd0, 8'd1, 8'd5, 8'd9});
      cycle(1'b0, 1'b0, 8'hEE);
      if (p == 9) begin
        check("gap_hold", 64'(data_o), {40'd0, 8'd1, 8'd5, 8'd9});
        check("gap_valid", 64'(valid_o), 64'd0);
      end
    end

    // sof mid-frame on pixel 6.
    for (int p = 1; p <= 5; p++) cycle(1'b1, p == 1, DW'(p));
    cycle(1'b1, 1'b1, 8'd100);
    check("sof_taps", 64'(data_o), REPL ? 64'h646464 : 64'h000064);
    check("sof_valid", 64'(valid_o), 64'd0);
    check("sof_done", 64'(done_o), 64'd0);
    for (int p = 1; p <= 8; p++) begin
      cycle(1'b1, 1'b0, DW'(100 + p));
      if (p == 7) check("sof_p7_valid", 64'(valid_o), 64'd0);
      if (p == 8) begin
        check("sof_p8_valid", 64'(valid_o), 64'd1);
        check("sof_p8_taps", 64'(data_o), {40'd0, 8'd100, 8'd104, 8'd108});
      end
    end

    // sof without a write, then reset mid-line.
    cycle(1'b0, 1'b1, 8'h00);
    check("sof_idle_done", 64'(done_o), 64'd0);
    for (int p = 1; p <= 6; p++) cycle(1'b1, 1'b0, DW'(p + 20));
    do_reset();
    cycle(1'b1, 1'b0, 8'd55);
    check("post_rst_taps", 64'(data_o), REPL ? 64'h373737 : 64'h000037);

    // Randomized traffic with occasional frame restarts and resets.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) do_reset();
      else cycle(($urandom_range(0, 9) < 7), (r < 5), DW'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
